// File: rtl/instr_stream_gen_pkg.sv
// Shared types, opcode constants and instruction encoders for the instruction stream generator.
// Holds the fixed Fibonacci program and the Galois LFSR feedback mask.
package instr_stream_pkg;

  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_ADD  = 7'b0110011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {OP_ADDI = 2'd0, OP_ADD = 2'd1, OP_BEQ = 2'd2, OP_JAL = 2'd3} instr_op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_e;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, OPC_ADDI};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0000000, rs2, rs1, 3'b000, rd, OPC_ADD};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BEQ};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_MASK : 32'h0);
  endfunction

  // x1/x2 hold the running pair; entries 2..5 form the loop body, 5 jumps back to 2
  localparam logic [31:0] FIB_ROM [0:5] = '{
    enc_i(12'd0, 5'd0, 5'd1),
    enc_i(12'd1, 5'd0, 5'd2),
    enc_r(5'd2, 5'd1, 5'd3),
    enc_i(12'd0, 5'd2, 5'd1),
    enc_i(12'd0, 5'd3, 5'd2),
    enc_j(21'h1FFFF4, 5'd0)
  };
  localparam instr_op_e FIB_OP [0:5] = '{OP_ADDI, OP_ADDI, OP_ADD, OP_ADDI, OP_ADDI, OP_JAL};

endpackage

// File: rtl/instr_stream_gen_if.sv
// Valid/ready instruction channel between the generator and the consumer core.
interface instr_stream_gen_if
  import instr_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instruction;
  instr_op_e             instr_op;

  modport master (output instr_valid, instruction, instr_op, input instr_ready);
  modport slave  (input instr_valid, instruction, instr_op, output instr_ready);
endinterface

// File: rtl/instr_stream_gen_lfsr.sv
// Right-shifting Galois LFSR; advances one step per cycle while en is high.
module lfsr_galois #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MASK  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  // the all-zero state is a lock-up point, so a zero seed becomes 1
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {1'b0, q_q[WIDTH-1:1]} ^ (q_q[0] ? MASK : '0);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) q_q <= SEED_NZ;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/instr_stream_gen.sv
// On-chip RISC-V instruction source: weighted random ADDI/ADD/BEQ/JAL or a fixed Fibonacci
// program, emitted over a valid/ready channel with a programmable instruction count.
module instr_stream_gen
  import instr_stream_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DIR_WIDTH  = 5,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] SEED       = 32'hACE1_0001,
  parameter int          W_ADDI     = 4,
  parameter int          W_ADD      = 4,
  parameter int          W_BEQ      = 1,
  parameter int          W_JAL      = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] num_instr,
  input  logic                 abort,
  instr_stream_gen_if.master   ifc,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 busy,
  output logic                 done
);
  localparam int WSUM   = W_ADDI + W_ADD + W_BEQ + W_JAL;
  localparam int WSUM_D = (WSUM > 0) ? WSUM : 1;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("instr_stream_gen: DATA_WIDTH must be 32");
  end
  if (DIR_WIDTH != 5) begin : g_bad_rw
    $error("instr_stream_gen: DIR_WIDTH must be 5");
  end
  if (WSUM <= 0) begin : g_bad_w
    $error("instr_stream_gen: instruction weights sum to zero");
  end

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, cnt_inc;
  logic [2:0]            fib_ptr_q, fib_ptr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  instr_op_e             op_q, op_d;
  logic                  valid_q, valid_d;
  logic                  load, hs;

  logic [31:0]           lfsr_q, lfsr_l;
  int                    r;
  logic [DIR_WIDTH-1:0]  rd, rs1, rs2;
  logic [31:0]           rnd_instr, nxt_instr;
  instr_op_e             rnd_op, nxt_op;

  lfsr_galois #(.WIDTH(32), .MASK(LFSR_MASK), .SEED(SEED)) u_lfsr (
    .clk (clk),
    .arst(arst),
    .en  (load & ~mode_q),
    .q   (lfsr_q)
  );

  // the draw uses the value the LFSR takes on this same load edge
  always_comb begin
    lfsr_l = lfsr_step(lfsr_q);
    r      = int'(lfsr_l[7:0]) % WSUM_D;
    rd     = lfsr_l[12:8];
    rs1    = lfsr_l[17:13];
    rs2    = lfsr_l[22:18];
    rnd_op = OP_JAL;
    if (r < W_ADDI)                      rnd_op = OP_ADDI;
    else if (r < W_ADDI + W_ADD)         rnd_op = OP_ADD;
    else if (r < W_ADDI + W_ADD + W_BEQ) rnd_op = OP_BEQ;
    unique case (rnd_op)
      OP_ADDI: rnd_instr = enc_i(lfsr_l[31:20], rs1, rd);
      OP_ADD:  rnd_instr = enc_r(rs2, rs1, rd);
      OP_BEQ:  rnd_instr = enc_b({lfsr_l[31:20], 1'b0}, rs2, rs1);
      default: rnd_instr = enc_j({lfsr_l[31:12], 1'b0}, rd);
    endcase
    nxt_instr = mode_q ? FIB_ROM[fib_ptr_q] : rnd_instr;
    nxt_op    = mode_q ? FIB_OP[fib_ptr_q]  : rnd_op;
  end

  assign hs      = valid_q & ifc.instr_ready;
  assign cnt_inc = count_q + CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    count_d   = count_q;
    fib_ptr_d = fib_ptr_q;
    instr_d   = instr_q;
    op_d      = op_q;
    valid_d   = valid_q;
    load      = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        mode_d    = mode;
        num_d     = num_instr;
        count_d   = '0;
        fib_ptr_d = '0;
        state_d   = (num_instr == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: if (abort) begin
        state_d = S_FIN;
      end else begin
        load    = 1'b1;
        valid_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (hs) count_d = cnt_inc;
        // a handshake on the abort edge still counts, but nothing new is loaded
        if (abort || (hs && cnt_inc == num_q)) begin
          valid_d = 1'b0;
          state_d = S_FIN;
        end else if (hs) begin
          load = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      instr_d   = nxt_instr;
      op_d      = nxt_op;
      fib_ptr_d = (fib_ptr_q == 3'd5) ? 3'd2 : fib_ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mode_q    <= 1'b0;
      num_q     <= '0;
      count_q   <= '0;
      fib_ptr_q <= '0;
      instr_q   <= '0;
      op_q      <= OP_ADDI;
      valid_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      num_q     <= num_d;
      count_q   <= count_d;
      fib_ptr_q <= fib_ptr_d;
      instr_q   <= instr_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
    end
  end

  assign ifc.instr_valid = valid_q;
  assign ifc.instruction = instr_q;
  assign ifc.instr_op    = op_q;
  assign instr_count     = count_q;
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_FIN);
endmodule

// File: tb/tb_instr_stream_gen.sv
// Bench for instr_stream_gen: table of Fibonacci runs, randomized-ready random runs checked
// against an arithmetic model, abort, ignored start, zero-length run and async reset.
module tb_instr_stream_gen;
  localparam logic [31:0] SEED_V = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        arst, start, mode, abort, rdy;
  logic [15:0] num_instr;
  logic [15:0] cnt1, cnt2;
  logic        busy1, done1, busy2, done2;

  instr_stream_gen_if #(.DATA_WIDTH(32)) ifc ();
  instr_stream_gen_if #(.DATA_WIDTH(32)) ifc_w ();
  assign ifc.instr_ready   = rdy;
  assign ifc_w.instr_ready = 1'b1;

  instr_stream_gen #(.W_ADDI(4), .W_ADD(4), .W_BEQ(0), .W_JAL(0)) dut (
    .clk(clk), .arst(arst), .start(start), .mode(mode), .num_instr(num_instr), .abort(abort),
    .ifc(ifc), .instr_count(cnt1), .busy(busy1), .done(done1));

  instr_stream_gen dut_w (
    .clk(clk), .arst(arst), .start(start), .mode(mode), .num_instr(num_instr), .abort(abort),
    .ifc(ifc_w), .instr_count(cnt2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  logic [31:0] q1[$], q2[$];
  logic [1:0]  o1[$], o2[$];
  int t_valid, t_done;
  logic [31:0] mdl1, mdl2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic void draw(input logic [31:0] l, input int wa, input int wd, input int wb,
                               input int wj, output logic [31:0] ins, output logic [1:0] op);
    int r;
    logic [31:0] rd, rs1, rs2, imm;
    r   = int'(l[7:0]) % (wa + wd + wb + wj);
    rd  = (l >> 8) & 32'd31;
    rs1 = (l >> 13) & 32'd31;
    rs2 = (l >> 18) & 32'd31;
    if (r < wa) begin
      op = 2'd0; ins = ((l >> 20) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
    end else if (r < wa + wd) begin
      op = 2'd1; ins = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
    end else if (r < wa + wd + wb) begin
      op = 2'd2; imm = (l >> 20) << 1;
      ins = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (rs2 << 20) |
            (rs1 << 15) | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'h63;
    end else begin
      op = 2'd3; imm = (l >> 12) << 1;
      ins = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
            (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | (rd << 7) | 32'h6F;
    end
  endfunction

  // start a run and collect every handshake until done (or a cycle budget runs out)
  task automatic do_run(input logic m, input int n, input bit rnd_rdy, input int abort_hs,
                        input bit spam);
    logic [31:0] hi;
    logic [1:0]  ho;
    bit hold, fin;
    int hs, c;
    hold = 0; fin = 0; hs = 0;
    q1.delete(); o1.delete(); q2.delete(); o2.delete();
    t_valid = -1; t_done = -1;
    mode = m; num_instr = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1;
    while (!fin && c < 3000) begin
      if (ifc.instr_valid && t_valid < 0) t_valid = c;
      if (ifc_w.instr_valid) begin q2.push_back(ifc_w.instruction); o2.push_back(ifc_w.instr_op); end
      if (done1) begin
        t_done = c; fin = 1;
      end else begin
        if (ifc.instr_valid) begin
          chk("busy_in_run", 32'(busy1), 32'd1);
          if (hold) begin
            chk("stable_instr", ifc.instruction, hi);
            chk("stable_op", 32'(ifc.instr_op), 32'(ho));
          end
          rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          if (abort_hs > 0 && hs == abort_hs - 1) begin rdy = 1'b1; abort = 1'b1; end
          if (spam && hs == 1) begin start = 1'b1; num_instr = 16'd77; mode = ~m; end
          if (rdy) begin
            q1.push_back(ifc.instruction); o1.push_back(ifc.instr_op); hs++; hold = 0;
          end else begin
            hold = 1; hi = ifc.instruction; ho = ifc.instr_op;
          end
        end
        @(negedge clk);
        abort = 1'b0; start = 1'b0; c++;
      end
    end
    if (!fin) chk("run_timeout", 32'(c), 32'd0);
  endtask

  typedef struct { logic [31:0] instr; logic [1:0] op; } beat_t;
  typedef struct { logic m; int n; int abort_hs; bit spam; int exp_cnt; int exp_tv; int exp_td; } run_t;
  beat_t fib_tab[9];
  run_t  runs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ei;
    logic [1:0]  eo;
    bit ok;
    fib_tab[0] = '{32'h00000093, 2'd0};
    fib_tab[1] = '{32'h00100113, 2'd0};
    fib_tab[2] = '{32'h002081B3, 2'd1};
    fib_tab[3] = '{32'h00010093, 2'd0};
    fib_tab[4] = '{32'h00018113, 2'd0};
    fib_tab[5] = '{32'hFF5FF06F, 2'd3};
    fib_tab[6] = fib_tab[2];
    fib_tab[7] = fib_tab[3];
    fib_tab[8] = fib_tab[4];
    runs[0] = '{1'b1, 6, 0, 1'b0, 6, 2, 8};
    runs[1] = '{1'b1, 9, 0, 1'b0, 9, 2, 11};
    runs[2] = '{1'b1, 0, 0, 1'b0, 0, -1, 1};
    runs[3] = '{1'b1, 10, 3, 1'b1, 3, 2, 5};

    arst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; rdy = 1'b0; num_instr = '0;
    @(negedge clk);
    chk("rst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_instr", ifc.instruction, 32'd0);
    chk("rst_op", 32'(ifc.instr_op), 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    arst = 1'b0;
    mdl1 = SEED_V; mdl2 = SEED_V;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_run(runs[i].m, runs[i].n, 1'b0, runs[i].abort_hs, runs[i].spam);
      chk($sformatf("run%0d_beats", i), 32'(q1.size()), 32'(runs[i].exp_cnt));
      for (int k = 0; k < q1.size() && k < 9; k++) begin
        chk($sformatf("run%0d_instr%0d", i, k), q1[k], fib_tab[k].instr);
        chk($sformatf("run%0d_op%0d", i, k), 32'(o1[k]), 32'(fib_tab[k].op));
      end
      chk($sformatf("run%0d_first_valid", i), 32'(t_valid), 32'(runs[i].exp_tv));
      chk($sformatf("run%0d_done_cycle", i), 32'(t_done), 32'(runs[i].exp_td));
      chk($sformatf("run%0d_count", i), 32'(cnt1), 32'(runs[i].exp_cnt));
      chk($sformatf("run%0d_valid_at_done", i), 32'(ifc.instr_valid), 32'd0);
      chk($sformatf("run%0d_busy_at_done", i), 32'(busy1), 32'd0);
      @(negedge clk);
      chk($sformatf("run%0d_done_pulse", i), 32'(done1), 32'd0);
      chk($sformatf("run%0d_count_hold", i), 32'(cnt1), 32'(runs[i].exp_cnt));
      repeat (2) @(negedge clk);
    end

    // random mode: two runs back to back, the second continuing the LFSR sequence
    for (int j = 0; j < 2; j++) begin
      int n;
      n = (j == 0) ? 100 : 20;
      do_run(1'b0, n, 1'b1, 0, 1'b0);
      chk("rnd_beats", 32'(q1.size()), 32'(n));
      chk("rnd_count", 32'(cnt1), 32'(n));
      chk("rnd_w_beats", 32'(q2.size()), 32'(n));
      for (int k = 0; k < n; k++) begin
        mdl1 = step(mdl1);
        mdl2 = step(mdl2);
        if (k < q1.size()) begin
          draw(mdl1, 4, 4, 0, 0, ei, eo);
          ok = (q1[k][6:0] == 7'b0010011) || (q1[k][6:0] == 7'b0110011);
          chk($sformatf("rnd%0d_opc_set%0d", j, k), 32'(ok), 32'd1);
          chk($sformatf("rnd%0d_instr%0d", j, k), q1[k], ei);
          chk($sformatf("rnd%0d_op%0d", j, k), 32'(o1[k]), 32'(eo));
        end
        if (k < q2.size()) begin
          draw(mdl2, 4, 4, 1, 1, ei, eo);
          chk($sformatf("rndw%0d_instr%0d", j, k), q2[k], ei);
          chk($sformatf("rndw%0d_op%0d", j, k), 32'(o2[k]), 32'(eo));
        end
      end
      repeat (3) @(negedge clk);
    end

    // reset in the middle of a random run clears outputs without waiting for a clock edge
    mode = 1'b0; num_instr = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin rdy = 1'($urandom_range(0, 1)); @(negedge clk); end
    #3 arst = 1'b1;
    #1;
    chk("arst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("arst_instr", ifc.instruction, 32'd0);
    chk("arst_op", 32'(ifc.instr_op), 32'd0);
    chk("arst_count", 32'(cnt1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    mdl1 = SEED_V;
    @(negedge clk);
    do_run(1'b0, 5, 1'b0, 0, 1'b0);
    chk("post_rst_beats", 32'(q1.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      mdl1 = step(mdl1);
      draw(mdl1, 4, 4, 0, 0, ei, eo);
      if (k < q1.size()) chk($sformatf("post_rst_instr%0d", k), q1[k], ei);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
